// File: rtl/traffic_phase_ctrl.sv
// Two-road traffic light phase sequencer driven by a divided tick clock.
// Optional pedestrian walk/early-exit logic compiled in with `define TRAFFIC_PED_EN.
module traffic_phase_ctrl #(
    parameter int GREEN_T     = 10,
    parameter int YELLOW_T    = 3,
    parameter int RED_T       = 2,
    parameter int MIN_GREEN_T = 4,
    parameter int WALK_T      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase,
    output logic [7:0] remain
);

    typedef enum logic [2:0] {
        RED_A = 3'd0,
        NS_G  = 3'd1,
        NS_Y  = 3'd2,
        RED_B = 3'd3,
        EW_G  = 3'd4,
        EW_Y  = 3'd5
    } state_t;

    localparam logic [7:0] GREEN_LD  = 8'(GREEN_T - 1);
    localparam logic [7:0] YELLOW_LD = 8'(YELLOW_T - 1);
    localparam logic [7:0] RED_LD    = 8'(RED_T - 1);

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    state_t     state_q, state_d, nxt_state;
    logic [7:0] cnt_q, cnt_d;
    logic       tick_d_q;
    logic       walk_q, walk_d;
    logic       ack_q, ack_d;
    logic [2:0] ns_q, ns_d, ew_q, ew_d;
    logic       tick, enter, early_exit, ped_pend_w, walk_entry;

    assign tick = tick_in & ~tick_d_q;

    function automatic logic [7:0] load_of(input state_t s);
        case (s)
            NS_G, EW_G: load_of = GREEN_LD;
            NS_Y, EW_Y: load_of = YELLOW_LD;
            default:    load_of = RED_LD;
        endcase
    endfunction

`ifdef TRAFFIC_PED_EN
    localparam logic [7:0] WALK_LD   = 8'(WALK_T - 1);
    localparam logic [7:0] PED_LIMIT = 8'(GREEN_T - MIN_GREEN_T);

    logic pend_q, pend_d;

    assign ped_pend_w = pend_q;
    assign early_exit = pend_q && (state_q == NS_G || state_q == EW_G) && (cnt_q <= PED_LIMIT);

    // A request seen on the very clk of walk entry survives for the next all-red phase.
    always_comb begin
        pend_d = pend_q | ped_req;
        if (walk_entry) begin
            pend_d = ped_req;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end
`else
    localparam int unused_cfg = WALK_T + MIN_GREEN_T;
    logic unused_ped;

    assign ped_pend_w = 1'b0;
    assign early_exit = 1'b0;
    assign unused_ped = ped_req ^ walk_entry;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RED_A;
            cnt_q    <= RED_LD;
            tick_d_q <= 1'b0;
            walk_q   <= 1'b0;
            ack_q    <= 1'b0;
            ns_q     <= LAMP_R;
            ew_q     <= LAMP_R;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tick_d_q <= tick_in;
            walk_q   <= walk_d;
            ack_q    <= ack_d;
            ns_q     <= ns_d;
            ew_q     <= ew_d;
        end
    end

    always_comb begin
        case (state_q)
            RED_A:   nxt_state = NS_G;
            NS_G:    nxt_state = NS_Y;
            NS_Y:    nxt_state = RED_B;
            RED_B:   nxt_state = EW_G;
            EW_G:    nxt_state = EW_Y;
            default: nxt_state = RED_A;
        endcase

        state_d    = state_q;
        cnt_d      = cnt_q;
        walk_d     = walk_q;
        ack_d      = 1'b0;
        enter      = 1'b0;
        walk_entry = 1'b0;

        // Illegal encodings fall back to RED_A without waiting for a tick.
        if (state_q > EW_Y) begin
            enter = 1'b1;
        end else if (tick) begin
            if (cnt_q == 8'd0 || early_exit) begin
                enter = 1'b1;
            end else begin
                cnt_d = cnt_q - 8'd1;
            end
        end

        if (enter) begin
            state_d    = nxt_state;
            cnt_d      = load_of(nxt_state);
            walk_d     = 1'b0;
            walk_entry = (nxt_state == RED_A || nxt_state == RED_B) && ped_pend_w;
`ifdef TRAFFIC_PED_EN
            if (walk_entry) begin
                cnt_d  = WALK_LD;
                walk_d = 1'b1;
                ack_d  = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        ns_d = LAMP_R;
        ew_d = LAMP_R;
        case (state_d)
            NS_G:    ns_d = LAMP_G;
            NS_Y:    ns_d = LAMP_Y;
            EW_G:    ew_d = LAMP_G;
            EW_Y:    ew_d = LAMP_Y;
            default: ;
        endcase
    end

    assign ns_light = ns_q;
    assign ew_light = ew_q;
    assign walk     = walk_q;
    assign ped_ack  = ack_q;
    assign phase    = state_q;
    assign remain   = cnt_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Randomized bench for traffic_phase_ctrl against a tick-level phase model.
// Expectations follow `TRAFFIC_PED_EN the same way the design does.
module tb_traffic_phase_ctrl;

    localparam int GREEN_T     = 10;
    localparam int YELLOW_T    = 3;
    localparam int RED_T       = 2;
    localparam int MIN_GREEN_T = 4;
    localparam int WALK_T      = 6;
`ifdef TRAFFIC_PED_EN
    localparam bit PED_EN = 1'b1;
`else
    localparam bit PED_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_in;
    logic       ped_req;
    logic [2:0] ns_light, ew_light, phase;
    logic       walk, ped_ack;
    logic [7:0] remain;

    traffic_phase_ctrl #(
        .GREEN_T    (GREEN_T),
        .YELLOW_T   (YELLOW_T),
        .RED_T      (RED_T),
        .MIN_GREEN_T(MIN_GREEN_T),
        .WALK_T     (WALK_T)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tick_in (tick_in),
        .ped_req (ped_req),
        .ns_light(ns_light),
        .ew_light(ew_light),
        .walk    (walk),
        .ped_ack (ped_ack),
        .phase   (phase),
        .remain  (remain)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: phase index, ticks spent in phase, phase length in ticks.
    int   m_phase, m_elapsed, m_dur;
    bit   m_walk, m_ack, m_pend, m_prev;
    int   m_ack_total = 0;
    int   dut_ack_total = 0;
    logic tin_v = 1'b0;
    int   half_cnt = 4;
    int   hold = 0;

    task automatic check_value(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int dur_of(input int p);
        if (p == 1 || p == 4) return GREEN_T;
        if (p == 2 || p == 5) return YELLOW_T;
        return RED_T;
    endfunction

    function automatic int lamp_of(input int p, input int green_phase);
        if (p == green_phase) return 1;
        if (p == green_phase + 1) return 2;
        return 4;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_elapsed = 0; m_dur = RED_T;
        m_walk = 0; m_ack = 0; m_pend = 0; m_prev = 0;
    endtask

    task automatic model_step(input logic tin, input logic preq);
        bit tk, old_pend, done;
        tk = tin && !m_prev;
        m_prev = tin;
        old_pend = m_pend;
        if (PED_EN && preq) m_pend = 1;
        m_ack = 0;
        if (tk) begin
            m_elapsed++;
            done = (m_elapsed >= m_dur) ||
                   (PED_EN && old_pend && (m_phase == 1 || m_phase == 4) && m_elapsed >= MIN_GREEN_T);
            if (done) begin
                m_phase = (m_phase + 1) % 6;
                m_elapsed = 0;
                m_walk = 0;
                m_dur = dur_of(m_phase);
                if (PED_EN && old_pend && (m_phase == 0 || m_phase == 3)) begin
                    m_dur = WALK_T;
                    m_walk = 1;
                    m_ack = 1;
                    m_ack_total++;
                    m_pend = preq;
                end
            end
        end
    endtask

    task automatic check_outputs();
        check_value("phase", int'(phase), m_phase);
        check_value("remain", int'(remain), m_dur - 1 - m_elapsed);
        check_value("ns_light", int'(ns_light), lamp_of(m_phase, 1));
        check_value("ew_light", int'(ew_light), lamp_of(m_phase, 4));
        check_value("walk", int'(walk), int'(m_walk));
        check_value("ped_ack", int'(ped_ack), int'(m_ack));
        if (ped_ack) dut_ack_total++;
    endtask

    task automatic drive_cycle(input bit rand_period, input logic preq);
        @(negedge clk);
        half_cnt--;
        if (half_cnt <= 0) begin
            tin_v = ~tin_v;
            half_cnt = rand_period ? int'($urandom_range(5, 1)) : 4;
        end
        tick_in = tin_v;
        ped_req = preq;
        model_step(tin_v, preq);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic run_until(input int tgt_phase, input int tgt_remain);
        int n;
        n = 0;
        while (!(m_phase == tgt_phase && (m_dur - 1 - m_elapsed) == tgt_remain) && n < 600) begin
            drive_cycle(1'b0, 1'b0);
            n++;
        end
        check_value("reach_target", int'(n < 600), 1);
    endtask

    task automatic random_cycles(input int n);
        logic r;
        for (int i = 0; i < n; i++) begin
            r = 1'b0;
            if (hold > 0) begin
                r = 1'b1;
                hold--;
            end else if ($urandom_range(99) == 0) begin
                hold = int'($urandom_range(40, 0));
                r = 1'b1;
            end
            drive_cycle(1'b1, r);
        end
    endtask

    task automatic release_reset();
        tick_in = 1'b0;
        ped_req = 1'b0;
        tin_v = 1'b0;
        half_cnt = 4;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        tick_in = 1'b0;
        ped_req = 1'b0;
        model_reset();
        #2 rst = 1'b0;
        #1;
        check_outputs();
        release_reset();

        // Plain cycle, fixed tick period of 8 clk, no requests.
        for (int i = 0; i < 300; i++) drive_cycle(1'b0, 1'b0);
        $display("scenario plain cycle done: checks=%0d", checks);

        // Single-clk request after the first NS_G tick.
        run_until(1, GREEN_T - 2);
        drive_cycle(1'b0, 1'b1);
        for (int i = 0; i < 250; i++) drive_cycle(1'b0, 1'b0);
        $display("scenario early exit done: checks=%0d", checks);

        // Request in EW_G once past the minimum green.
        run_until(4, 2);
        drive_cycle(1'b0, 1'b1);
        for (int i = 0; i < 200; i++) drive_cycle(1'b0, 1'b0);
        $display("scenario late request done: checks=%0d", checks);

        // Request held across a walk phase.
        run_until(1, GREEN_T - 1);
        for (int i = 0; i < 160; i++) drive_cycle(1'b0, 1'b1);
        for (int i = 0; i < 250; i++) drive_cycle(1'b0, 1'b0);
        $display("scenario held request done: checks=%0d", checks);

        // Asynchronous reset in the middle of EW_Y.
        run_until(5, YELLOW_T - 2);
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        release_reset();
        for (int i = 0; i < 60; i++) drive_cycle(1'b0, 1'b0);
        $display("scenario async reset done: checks=%0d", checks);

        random_cycles(1500);
        $display("scenario random done: checks=%0d", checks);

        check_value("ack_total", dut_ack_total, m_ack_total);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
